// File: rtl/v30mz_pkg.sv
// Shared definitions for the v30mz bus control unit: command codes, bus
// status codes, arbiter FSM states and the command-to-status mapping.
package v30mz_pkg;

   localparam logic [2:0] BUS_COMMAND_IDLE      = 3'd0;
   localparam logic [2:0] BUS_COMMAND_MEM_READ  = 3'd1;
   localparam logic [2:0] BUS_COMMAND_MEM_WRITE = 3'd2;
   localparam logic [2:0] BUS_COMMAND_IO_READ   = 3'd3;
   localparam logic [2:0] BUS_COMMAND_IO_WRITE  = 3'd4;

   localparam logic [3:0] STATUS_IDLE      = 4'hf;
   localparam logic [3:0] STATUS_MEM_READ  = 4'b1001;
   localparam logic [3:0] STATUS_MEM_WRITE = 4'b1010;
   localparam logic [3:0] STATUS_IO_READ   = 4'b0101;
   localparam logic [3:0] STATUS_IO_WRITE  = 4'b0110;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUS1,
      ST_BUS2,
      ST_TURN
   } bus_state_t;

   function automatic logic [3:0] cmd_to_status(input logic [2:0] cmd);
      case (cmd)
         BUS_COMMAND_MEM_READ:  cmd_to_status = STATUS_MEM_READ;
         BUS_COMMAND_MEM_WRITE: cmd_to_status = STATUS_MEM_WRITE;
         BUS_COMMAND_IO_READ:   cmd_to_status = STATUS_IO_READ;
         BUS_COMMAND_IO_WRITE:  cmd_to_status = STATUS_IO_WRITE;
         default:               cmd_to_status = STATUS_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/v30mz_rr_arbiter.sv
// Rotating-priority arbiter: the first requester at or after 'pointer' wins.
// A pointer held at zero gives plain fixed priority (lowest index wins).
module v30mz_rr_arbiter #(
   parameter int NUM_CH = 2,
   parameter int PTR_W  = 1
) (
   input  logic [NUM_CH-1:0] request,
   input  logic [PTR_W-1:0]  pointer,
   output logic [NUM_CH-1:0] grant,
   output logic              grant_valid
);

   logic [2*NUM_CH-1:0] req_dbl;
   logic [2*NUM_CH-1:0] grant_dbl;
   logic [NUM_CH-1:0]   rot;
   logic [NUM_CH-1:0]   sel;

   // Rotate so the pointer channel sits at bit 0, isolate the lowest set bit,
   // then rotate back into channel order.
   assign req_dbl     = {request, request};
   assign rot         = NUM_CH'(req_dbl >> pointer);
   assign sel         = rot & (~rot + NUM_CH'(1));
   assign grant_dbl   = {{NUM_CH{1'b0}}, sel} << pointer;
   assign grant       = grant_dbl[NUM_CH-1:0] | grant_dbl[2*NUM_CH-1:NUM_CH];
   assign grant_valid = |request;

endmodule

// File: rtl/v30mz_bus_arbiter.sv
// Non-preemptive bus control unit multiplexing NUM_CH masters onto the 16-bit
// external bus, with odd-word splitting, fixed/rotating priority and timeout.
module v30mz_bus_arbiter
   import v30mz_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int ADDR_W      = 20,
   parameter int ROUND_ROBIN = 0,
   parameter int TIMEOUT     = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_CH-1:0]      req_valid,
   input  logic [NUM_CH*3-1:0]    req_cmd,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr,
   input  logic [NUM_CH-1:0]      req_word,
   input  logic [NUM_CH*16-1:0]   req_wdata,
   output logic [NUM_CH-1:0]      req_done,
   output logic [NUM_CH-1:0]      req_err,
   output logic [15:0]            rdata,
   input  logic                   readyb,
   input  logic [15:0]            data_in,
   output logic [15:0]            data_out,
   output logic [ADDR_W-1:0]      address_out,
   output logic [3:0]             bus_status,
   output logic                   bus_upper_byte_enable
);

   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   bus_state_t          state_reg, state_next;
   logic [PTR_W-1:0]    chan_reg, chan_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic                word_reg, word_next;
   logic [15:0]         wdata_reg, wdata_next;
   logic                split_reg, split_next;
   logic [7:0]          lo_byte_reg, lo_byte_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [PTR_W-1:0]    ptr_reg, ptr_next;
   logic [ADDR_W-1:0]   addr_out_reg, addr_out_next;
   logic [3:0]          status_reg, status_next;
   logic                ube_reg, ube_next;
   logic [15:0]         dout_reg, dout_next;
   logic [15:0]         rdata_reg, rdata_next;
   logic [NUM_CH-1:0]   done_reg, done_next;
   logic [NUM_CH-1:0]   err_reg, err_next;

   logic [NUM_CH-1:0]   req_vec;
   logic [NUM_CH-1:0]   grant;
   logic                grant_valid;
   logic [PTR_W-1:0]    grant_idx;
   logic [PTR_W-1:0]    arb_ptr;
   logic [PTR_W-1:0]    ptr_after;
   logic [2:0]          win_cmd;
   logic [ADDR_W-1:0]   win_addr;
   logic                win_word;
   logic [15:0]         win_wdata;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_req
         assign req_vec[gi] = req_valid[gi] & (req_cmd[gi*3 +: 3] != BUS_COMMAND_IDLE);
      end
   endgenerate

   assign arb_ptr = (ROUND_ROBIN != 0) ? ptr_reg : '0;

   v30mz_rr_arbiter #(
      .NUM_CH (NUM_CH),
      .PTR_W  (PTR_W)
   ) u_arb (
      .request     (req_vec),
      .pointer     (arb_ptr),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) grant_idx = PTR_W'(i);
      end
   end

   assign win_cmd   = req_cmd[grant_idx*3 +: 3];
   assign win_addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
   assign win_word  = req_word[grant_idx];
   assign win_wdata = req_wdata[grant_idx*16 +: 16];
   assign ptr_after = (chan_reg == PTR_W'(NUM_CH - 1)) ? '0 : chan_reg + PTR_W'(1);

   always_comb begin
      state_next    = state_reg;
      chan_next     = chan_reg;
      addr_next     = addr_reg;
      word_next     = word_reg;
      wdata_next    = wdata_reg;
      split_next    = split_reg;
      lo_byte_next  = lo_byte_reg;
      cnt_next      = cnt_reg;
      ptr_next      = ptr_reg;
      addr_out_next = addr_out_reg;
      status_next   = status_reg;
      ube_next      = ube_reg;
      dout_next     = dout_reg;
      rdata_next    = rdata_reg;
      done_next     = '0;
      err_next      = '0;

      case (state_reg)
         ST_IDLE: begin
            if (grant_valid) begin
               chan_next     = grant_idx;
               addr_next     = win_addr;
               word_next     = win_word;
               wdata_next    = win_wdata;
               split_next    = win_word & win_addr[0];
               cnt_next      = '0;
               addr_out_next = win_addr;
               status_next   = cmd_to_status(win_cmd);
               ube_next      = win_word | win_addr[0];
               // An odd address always puts the low byte on the upper lane.
               if (win_addr[0])
                  dout_next = {win_wdata[7:0], win_wdata[7:0]};
               else if (win_word)
                  dout_next = win_wdata;
               else
                  dout_next = {8'h00, win_wdata[7:0]};
               state_next = ST_BUS1;
            end
         end

         ST_BUS1, ST_BUS2: begin
            if (!readyb) begin
               if (split_reg) begin
                  lo_byte_next  = data_in[15:8];
                  split_next    = 1'b0;
                  cnt_next      = '0;
                  addr_out_next = addr_reg + ADDR_W'(1);
                  ube_next      = 1'b0;
                  dout_next     = {8'h00, wdata_reg[15:8]};
                  state_next    = ST_BUS2;
               end else begin
                  if (state_reg == ST_BUS2)
                     rdata_next = {data_in[7:0], lo_byte_reg};
                  else if (word_reg)
                     rdata_next = data_in;
                  else if (addr_reg[0])
                     rdata_next = {8'h00, data_in[15:8]};
                  else
                     rdata_next = {8'h00, data_in[7:0]};
                  done_next     = NUM_CH'(1) << chan_reg;
                  if (ROUND_ROBIN != 0) ptr_next = ptr_after;
                  addr_out_next = '0;
                  status_next   = STATUS_IDLE;
                  ube_next      = 1'b0;
                  dout_next     = '0;
                  state_next    = ST_TURN;
               end
            end else if ((TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
               err_next      = NUM_CH'(1) << chan_reg;
               if (ROUND_ROBIN != 0) ptr_next = ptr_after;
               split_next    = 1'b0;
               addr_out_next = '0;
               status_next   = STATUS_IDLE;
               ube_next      = 1'b0;
               dout_next     = '0;
               state_next    = ST_TURN;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         ST_TURN: state_next = ST_IDLE;

         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         chan_reg     <= '0;
         addr_reg     <= '0;
         word_reg     <= 1'b0;
         wdata_reg    <= '0;
         split_reg    <= 1'b0;
         lo_byte_reg  <= '0;
         cnt_reg      <= '0;
         ptr_reg      <= '0;
         addr_out_reg <= '0;
         status_reg   <= STATUS_IDLE;
         ube_reg      <= 1'b0;
         dout_reg     <= '0;
         rdata_reg    <= '0;
         done_reg     <= '0;
         err_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         chan_reg     <= chan_next;
         addr_reg     <= addr_next;
         word_reg     <= word_next;
         wdata_reg    <= wdata_next;
         split_reg    <= split_next;
         lo_byte_reg  <= lo_byte_next;
         cnt_reg      <= cnt_next;
         ptr_reg      <= ptr_next;
         addr_out_reg <= addr_out_next;
         status_reg   <= status_next;
         ube_reg      <= ube_next;
         dout_reg     <= dout_next;
         rdata_reg    <= rdata_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
      end
   end

   assign req_done              = done_reg;
   assign req_err               = err_reg;
   assign rdata                 = rdata_reg;
   assign data_out              = dout_reg;
   assign address_out           = addr_out_reg;
   assign bus_status            = status_reg;
   assign bus_upper_byte_enable = ube_reg;

endmodule

// File: tb/tb_v30mz_bus_arbiter.sv
// Self-checking bench: the bench acts as bus slave and predicts every bus phase
// and completion from the lane/priority rules of the bus control unit.
module tb_v30mz_bus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [1:0]  ch_valid;
   logic [2:0]  ch_cmd [2];
   logic [19:0] ch_addr [2];
   logic [1:0]  ch_word;
   logic [15:0] ch_wdata [2];
   logic        readyb;
   logic [15:0] data_in;
   logic        sel;

   logic [5:0]  req_cmd;
   logic [39:0] req_addr;
   logic [31:0] req_wdata;
   assign req_cmd   = {ch_cmd[1], ch_cmd[0]};
   assign req_addr  = {ch_addr[1], ch_addr[0]};
   assign req_wdata = {ch_wdata[1], ch_wdata[0]};

   logic [1:0]  rr_done, rr_err, fp_done, fp_err;
   logic [15:0] rr_rdata, rr_dout, fp_rdata, fp_dout;
   logic [19:0] rr_addr, fp_addr;
   logic [3:0]  rr_status, fp_status;
   logic        rr_ube, fp_ube;

   // Observed outputs of whichever instance is under test.
   logic [1:0]  o_done, o_err;
   logic [15:0] o_rdata, o_dout;
   logic [19:0] o_addr;
   logic [3:0]  o_status;
   logic        o_ube;
   assign o_done   = sel ? fp_done   : rr_done;
   assign o_err    = sel ? fp_err    : rr_err;
   assign o_rdata  = sel ? fp_rdata  : rr_rdata;
   assign o_dout   = sel ? fp_dout   : rr_dout;
   assign o_addr   = sel ? fp_addr   : rr_addr;
   assign o_status = sel ? fp_status : rr_status;
   assign o_ube    = sel ? fp_ube    : rr_ube;

   v30mz_bus_arbiter #(.NUM_CH(2), .ADDR_W(20), .ROUND_ROBIN(1), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .req_valid(ch_valid), .req_cmd(req_cmd),
      .req_addr(req_addr), .req_word(ch_word), .req_wdata(req_wdata),
      .req_done(rr_done), .req_err(rr_err), .rdata(rr_rdata), .readyb(readyb),
      .data_in(data_in), .data_out(rr_dout), .address_out(rr_addr),
      .bus_status(rr_status), .bus_upper_byte_enable(rr_ube)
   );

   v30mz_bus_arbiter #(.NUM_CH(2), .ADDR_W(20), .ROUND_ROBIN(0), .TIMEOUT(0)) dut_fp (
      .clk(clk), .reset(reset), .req_valid(ch_valid), .req_cmd(req_cmd),
      .req_addr(req_addr), .req_word(ch_word), .req_wdata(req_wdata),
      .req_done(fp_done), .req_err(fp_err), .rdata(fp_rdata), .readyb(readyb),
      .data_in(data_in), .data_out(fp_dout), .address_out(fp_addr),
      .bus_status(fp_status), .bus_upper_byte_enable(fp_ube)
   );

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [3:0] exp_status(input logic [2:0] cmd);
      case (cmd)
         3'd1:    return 4'b1001;
         3'd2:    return 4'b1010;
         3'd3:    return 4'b0101;
         3'd4:    return 4'b0110;
         default: return 4'hf;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge where reset has taken effect.
   task automatic do_reset();
      reset    = 1'b1;
      ch_valid = 2'b00;
      readyb   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Runs one transaction for channel ch (requests already driven), applying
   // nwait wait cycles per bus phase. lead = posedges until the arbitrating edge.
   task automatic run_txn(input int ch, input int nwait, input int lead);
      logic [2:0]  cmd;
      logic [19:0] a;
      logic        wd;
      logic [15:0] wdat;
      logic [3:0]  st;
      logic        is_wr;
      int          nph;
      logic [19:0] pa [2];
      logic        pu [2];
      logic [15:0] pm [2];
      logic [15:0] pv [2];
      logic [15:0] smp [2];
      logic [15:0] exp_rd;
      logic [1:0]  exp_done;
      cmd   = ch_cmd[ch];
      a     = ch_addr[ch];
      wd    = ch_word[ch];
      wdat  = ch_wdata[ch];
      st    = exp_status(cmd);
      is_wr = (cmd == 3'd2) || (cmd == 3'd4);
      nph   = (wd && a[0]) ? 2 : 1;
      pa[0] = a;
      pa[1] = a + 20'd1;
      pu[0] = wd | a[0];
      pu[1] = 1'b0;
      pm[1] = 16'h0000;
      pv[1] = 16'h0000;
      if (wd && a[0]) begin
         pm[0] = 16'hff00; pv[0] = {wdat[7:0], 8'h00};
         pm[1] = 16'h00ff; pv[1] = {8'h00, wdat[15:8]};
      end else if (wd) begin
         pm[0] = 16'hffff; pv[0] = wdat;
      end else if (a[0]) begin
         pm[0] = 16'hffff; pv[0] = {wdat[7:0], wdat[7:0]};
      end else begin
         pm[0] = 16'h00ff; pv[0] = {8'h00, wdat[7:0]};
      end
      smp[0] = 16'h0000;
      smp[1] = 16'h0000;
      $display("txn ch%0d cmd%0d addr %05h word %0d wdata %04h waits %0d", ch, cmd, a, wd, wdat, nwait);

      for (int l = 0; l < lead; l++) begin
         @(posedge clk);
         if (l < lead - 1) begin
            @(negedge clk);
            n_vec++;
            if (o_status !== 4'hf) begin
               n_err++; $display("FAIL idle_status: got %h want f", o_status);
            end
         end
      end

      for (int p = 0; p < nph; p++) begin
         for (int w = 0; w <= nwait; w++) begin
            @(negedge clk);
            n_vec++;
            if (o_status !== st) begin
               n_err++; $display("FAIL status ph%0d w%0d: got %h want %h", p, w, o_status, st);
            end
            n_vec++;
            if (o_addr !== pa[p]) begin
               n_err++; $display("FAIL address ph%0d w%0d: got %05h want %05h", p, w, o_addr, pa[p]);
            end
            n_vec++;
            if (o_ube !== pu[p]) begin
               n_err++; $display("FAIL upper_lane ph%0d: got %b want %b", p, o_ube, pu[p]);
            end
            n_vec++;
            if (o_done !== 2'b00 || o_err !== 2'b00) begin
               n_err++; $display("FAIL early_pulse ph%0d: got done %b err %b want 00", p, o_done, o_err);
            end
            if (is_wr) begin
               n_vec++;
               if ((o_dout & pm[p]) !== pv[p]) begin
                  n_err++; $display("FAIL data_out ph%0d: got %04h want %04h mask %04h", p, o_dout, pv[p], pm[p]);
               end
            end
            readyb  = (w < nwait);
            data_in = 16'($urandom);
            smp[p]  = data_in;
         end
      end

      @(negedge clk);
      exp_done = 2'b01 << ch;
      n_vec++;
      if (o_done !== exp_done || o_err !== 2'b00) begin
         n_err++; $display("FAIL done: got done %b err %b want done %b", o_done, o_err, exp_done);
      end
      n_vec++;
      if (o_status !== 4'hf) begin
         n_err++; $display("FAIL turn_status: got %h want f", o_status);
      end
      if (!is_wr) begin
         if (wd && a[0])  exp_rd = {smp[1][7:0], smp[0][15:8]};
         else if (wd)     exp_rd = smp[0];
         else if (a[0])   exp_rd = {8'h00, smp[0][15:8]};
         else             exp_rd = {8'h00, smp[0][7:0]};
         n_vec++;
         if (o_rdata !== exp_rd) begin
            n_err++; $display("FAIL rdata: got %04h want %04h", o_rdata, exp_rd);
         end
      end
      readyb = 1'b1;
   endtask

   task automatic set_req(input int c, input logic [2:0] cmd, input logic [19:0] a,
                          input logic wd, input logic [15:0] d);
      ch_valid[c] = 1'b1;
      ch_cmd[c]   = cmd;
      ch_addr[c]  = a;
      ch_word[c]  = wd;
      ch_wdata[c] = d;
   endtask

   task automatic test_reset();
      do_reset();
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         n_vec++;
         if (o_status !== 4'hf || o_addr !== 20'h0 || o_dout !== 16'h0 || o_rdata !== 16'h0 ||
             o_ube !== 1'b0 || o_done !== 2'b00 || o_err !== 2'b00) begin
            n_err++;
            $display("FAIL reset_values inst%0d: got st %h addr %05h dout %04h rd %04h ube %b done %b err %b want f/0",
                     s, o_status, o_addr, o_dout, o_rdata, o_ube, o_done, o_err);
         end
      end
      sel = 1'b0;
   endtask

   task automatic test_directed();
      sel = 1'b0;
      do_reset();
      set_req(0, 3'd1, 20'h00100, 1'b1, 16'h0000);
      run_txn(0, 0, 1);
      ch_valid = 2'b00;
      set_req(1, 3'd2, 20'h00201, 1'b0, 16'h005A);
      run_txn(1, 3, 2);
      n_vec++;
      if (rr_dout !== 16'h0000 && rr_status === 4'hf && rr_ube !== 1'b0) begin
         n_err++; $display("FAIL turn_lane: got ube %b want 0", rr_ube);
      end
      ch_valid = 2'b00;
      set_req(0, 3'd1, 20'hFFFFF, 1'b1, 16'h0000);
      run_txn(0, 0, 2);
      ch_valid = 2'b00;
      set_req(0, 3'd4, 20'h0FFFF, 1'b1, 16'hBEEF);
      run_txn(0, 1, 2);
      ch_valid = 2'b00;
   endtask

   task automatic test_priority(input logic rr);
      sel = ~rr;
      do_reset();
      set_req(0, 3'd1, 20'h00400, 1'b1, 16'h0000);
      set_req(1, 3'd1, 20'h00800, 1'b1, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         run_txn(rr ? (k % 2) : 0, 0, (k == 0) ? 1 : 2);
      end
      if (!rr) begin
         // A valid flag with command 0 is not a request.
         ch_cmd[0] = 3'd0;
         run_txn(1, 0, 2);
      end
      ch_valid = 2'b00;
      sel = 1'b0;
   endtask

   task automatic test_timeout();
      sel = 1'b0;
      do_reset();
      set_req(0, 3'd1, 20'h00100, 1'b1, 16'h0000);
      @(posedge clk);
      for (int w = 0; w < 4; w++) begin
         @(negedge clk);
         n_vec++;
         if (o_status !== 4'b1001 || o_err !== 2'b00) begin
            n_err++; $display("FAIL timeout_wait w%0d: got st %h err %b want 9/00", w, o_status, o_err);
         end
      end
      @(negedge clk);
      n_vec++;
      if (o_err !== 2'b01 || o_done !== 2'b00 || o_status !== 4'hf) begin
         n_err++; $display("FAIL timeout_err: got err %b done %b st %h want 01/00/f", o_err, o_done, o_status);
      end
      ch_valid = 2'b00;
      @(negedge clk);
      n_vec++;
      if (o_err !== 2'b00) begin
         n_err++; $display("FAIL timeout_pulse: got err %b want 00", o_err);
      end
      // The aborted grant still moves the rotating pointer on to channel 1.
      set_req(0, 3'd1, 20'h00400, 1'b0, 16'h0000);
      set_req(1, 3'd3, 20'h00801, 1'b0, 16'h0000);
      run_txn(1, 0, 1);
      ch_valid = 2'b00;
      sel = 1'b1;
      do_reset();
      set_req(1, 3'd2, 20'h00201, 1'b0, 16'h005A);
      run_txn(1, 6, 1);
      ch_valid = 2'b00;
      sel = 1'b0;
   endtask

   task automatic test_mid_reset();
      sel = 1'b0;
      do_reset();
      set_req(0, 3'd1, 20'hFFFFF, 1'b1, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      readyb = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (o_addr !== 20'h00000 || o_ube !== 1'b0 || o_status !== 4'b1001) begin
         n_err++; $display("FAIL bus2_phase: got addr %05h ube %b st %h want 00000/0/9", o_addr, o_ube, o_status);
      end
      do_reset();
      n_vec++;
      if (o_status !== 4'hf || o_addr !== 20'h0 || o_dout !== 16'h0 || o_rdata !== 16'h0 ||
          o_ube !== 1'b0 || o_done !== 2'b00 || o_err !== 2'b00) begin
         n_err++;
         $display("FAIL mid_reset: got st %h addr %05h dout %04h rd %04h ube %b done %b err %b want f/0",
                  o_status, o_addr, o_dout, o_rdata, o_ube, o_done, o_err);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_vec++;
         if (o_done !== 2'b00 || o_status !== 4'hf) begin
            n_err++; $display("FAIL post_reset%0d: got done %b st %h want 00/f", k, o_done, o_status);
         end
      end
   endtask

   task automatic test_random();
      int ptr;
      int win;
      int mask;
      int lead;
      sel = 1'b0;
      do_reset();
      ptr  = 0;
      lead = 1;
      for (int t = 0; t < 40; t++) begin
         mask = $urandom_range(1, 3);
         for (int c = 0; c < 2; c++) begin
            ch_valid[c] = ((mask >> c) & 1) != 0;
            ch_cmd[c]   = 3'($urandom_range(1, 4));
            ch_addr[c]  = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : 20'($urandom);
            ch_word[c]  = 1'($urandom);
            ch_wdata[c] = 16'($urandom);
         end
         if (mask == 3) win = ptr;
         else           win = (mask == 1) ? 0 : 1;
         run_txn(win, $urandom_range(0, 3), lead);
         ptr  = (win + 1) % 2;
         lead = 2;
      end
      ch_valid = 2'b00;
   endtask

   initial begin
      reset    = 1'b1;
      ch_valid = 2'b00;
      for (int c = 0; c < 2; c++) begin
         ch_cmd[c]   = 3'd0;
         ch_addr[c]  = 20'h0;
         ch_wdata[c] = 16'h0;
      end
      ch_word = 2'b00;
      readyb  = 1'b1;
      data_in = 16'h0;
      sel     = 1'b0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_priority(1'b1);
      test_priority(1'b0);
      test_timeout();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
